// File: rtl/ll_detect_ctrl.sv
// ll_detect_ctrl
// Detection controller that sits downstream of the windowed line-length sum.
// Each accepted sample (rst=0, en=0, sum_valid=1) is compared against signed
// onset/offset thresholds with hysteresis. Onset and offset must persist for
// n_on / n_off consecutive windows, and a holdoff of holdoff_len windows
// follows every offset.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (overrides en)
//   en              active-low enable; high freezes state and drops samples
//   sum_in          signed windowed sum
//   sum_valid       single-cycle qualifier for sum_in
//   thr_on, thr_off signed onset / offset thresholds (sampled live)
//   n_on, n_off     consecutive-window requirements (0 behaves as 1)
//   holdoff_len     valid windows ignored after an offset
//   detect          high while in DETECT
//   detect_start    one-cycle pulse after the sample that enters DETECT
//   detect_end      one-cycle pulse after the sample that leaves DETECT
//   event_count     saturating count of DETECT entries
//   state           IDLE=0, ONSET=1, DETECT=2, HOLDOFF=3
module ll_detect_ctrl #(
  parameter int SUM_WIDTH = 64,
  parameter int CNT_WIDTH = 8,
  parameter int EVT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [SUM_WIDTH-1:0] sum_in,
  input  logic                 sum_valid,
  input  logic [SUM_WIDTH-1:0] thr_on,
  input  logic [SUM_WIDTH-1:0] thr_off,
  input  logic [CNT_WIDTH-1:0] n_on,
  input  logic [CNT_WIDTH-1:0] n_off,
  input  logic [CNT_WIDTH-1:0] holdoff_len,
  output logic                 detect,
  output logic                 detect_start,
  output logic                 detect_end,
  output logic [EVT_WIDTH-1:0] event_count,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ONSET   = 2'd1,
    DETECT  = 2'd2,
    HOLDOFF = 2'd3
  } st_t;

  st_t                 st_q, st_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 enter, leave;

  // cnt+1 kept one bit wider so the >= compares never see a wrapped value
  logic [CNT_WIDTH:0]   cnt_inc;
  logic [CNT_WIDTH-1:0] cnt_sat;
  logic [CNT_WIDTH:0]   non_eff, noff_eff, hold_ext;
  logic                 above, below, accept;

  assign cnt_inc  = {1'b0, cnt_q} + 1'b1;
  assign cnt_sat  = cnt_inc[CNT_WIDTH] ? '1 : cnt_inc[CNT_WIDTH-1:0];
  assign non_eff  = (n_on  == '0) ? (CNT_WIDTH+1)'(1) : {1'b0, n_on};
  assign noff_eff = (n_off == '0) ? (CNT_WIDTH+1)'(1) : {1'b0, n_off};
  assign hold_ext = {1'b0, holdoff_len};
  assign above    = $signed(sum_in) > $signed(thr_on);
  assign below    = $signed(sum_in) < $signed(thr_off);
  assign accept   = sum_valid & ~en;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    enter = 1'b0;
    leave = 1'b0;
    case (st_q)
      IDLE: begin
        cnt_d = '0;
        if (above) begin
          if (non_eff == (CNT_WIDTH+1)'(1)) begin
            st_d  = DETECT;
            enter = 1'b1;
          end else begin
            st_d  = ONSET;
            cnt_d = CNT_WIDTH'(1);
          end
        end
      end
      ONSET: begin
        if (above) begin
          if (cnt_inc >= non_eff) begin
            st_d  = DETECT;
            cnt_d = '0;
            enter = 1'b1;
          end else begin
            cnt_d = cnt_sat;
          end
        end else begin
          st_d  = IDLE;
          cnt_d = '0;
        end
      end
      DETECT: begin
        if (below) begin
          if (cnt_inc >= noff_eff) begin
            st_d  = (holdoff_len == '0) ? IDLE : HOLDOFF;
            cnt_d = '0;
            leave = 1'b1;
          end else begin
            cnt_d = cnt_sat;
          end
        end else begin
          cnt_d = '0;
        end
      end
      HOLDOFF: begin
        // sum_in is deliberately ignored here
        if (cnt_inc >= hold_ext) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      default: begin
        st_d  = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= IDLE;
      cnt_q        <= '0;
      detect_start <= 1'b0;
      detect_end   <= 1'b0;
      event_count  <= '0;
    end else begin
      // pulses self-clear every clock, independent of en
      detect_start <= 1'b0;
      detect_end   <= 1'b0;
      if (accept) begin
        st_q         <= st_d;
        cnt_q        <= cnt_d;
        detect_start <= enter;
        detect_end   <= leave;
        if (enter && event_count != '1)
          event_count <= event_count + 1'b1;
      end
    end
  end

  assign detect = (st_q == DETECT);
  assign state  = st_q;

endmodule
